// File: rtl/tcam_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tcam_pkg
// Description : Shared sizing constants for the TCAM array and its encoder.
// Revision    : 1.0 - initial release
// ============================================================================
package tcam_pkg;
    localparam int N_ENTRIES = 256;
    localparam int ADDR_W    = 8;
    localparam int GROUP_W   = 16;
    localparam int N_GROUPS  = 16;
    localparam int CNT_W     = 16;
endpackage
`default_nettype wire

// File: rtl/prio16.sv
`default_nettype none
// ============================================================================
// Module      : prio16
// Description : 16-bit lowest-set-bit encoder with hit and multi flags.
// Revision    : 1.0 - initial release
// ============================================================================
module prio16 (
    input  logic [15:0] vec,
    output logic        hit,
    output logic [3:0]  idx,
    output logic        multi
);

    // Scan downwards so the lowest set bit is the last one written.
    always_comb begin
        idx = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (vec[i]) idx = 4'(i);
        end
    end

    assign hit   = |vec;
    assign multi = |(vec & (vec - 16'd1));

endmodule
`default_nettype wire

// File: rtl/tcam_prio_enc.sv
`default_nettype none
// ============================================================================
// Module      : tcam_prio_enc
// Description : Two-stage valid/ready priority encoder for TCAM match lines,
//               with saturating hit/miss statistics.
// Revision    : 1.0 - initial release
// ============================================================================
module tcam_prio_enc #(
    parameter int N_ENTRIES = tcam_pkg::N_ENTRIES,
    parameter int GROUP_W   = tcam_pkg::GROUP_W,
    parameter int CNT_W     = tcam_pkg::CNT_W
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [N_ENTRIES-1:0]        match,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        out_hit,
    output logic [tcam_pkg::ADDR_W-1:0] out_addr,
    output logic                        out_multi,
    input  logic                        cnt_clr,
    output logic [CNT_W-1:0]            hit_cnt,
    output logic [CNT_W-1:0]            miss_cnt
);
    import tcam_pkg::*;

    localparam int c_ngroups = N_ENTRIES / GROUP_W;

    logic                         w_s1_adv;
    logic                         w_s2_adv;
    logic                         w_out_hs;
    logic [c_ngroups-1:0]         w_g_hit;
    logic [c_ngroups-1:0][3:0]    w_g_idx;
    logic [c_ngroups-1:0]         w_g_multi;
    logic                         w_sel_hit;
    logic [3:0]                   w_sel_grp;
    logic                         w_sel_multi;
    logic [ADDR_W-1:0]            w_addr;
    logic                         w_multi;

    logic                         r_s1_valid;
    logic [c_ngroups-1:0]         r_g_hit;
    logic [c_ngroups-1:0][3:0]    r_g_idx;
    logic [c_ngroups-1:0]         r_g_multi;
    logic                         r_out_valid;
    logic                         r_out_hit;
    logic [ADDR_W-1:0]            r_out_addr;
    logic                         r_out_multi;
    logic [CNT_W-1:0]             r_hit_cnt;
    logic [CNT_W-1:0]             r_miss_cnt;

    assign w_s2_adv = !r_out_valid || out_ready;
    assign w_s1_adv = !r_s1_valid || w_s2_adv;
    assign w_out_hs = r_out_valid && out_ready;

    generate
        for (genvar gi = 0; gi < c_ngroups; gi++) begin : g_grp
            prio16 u_grp (
                .vec   (match[gi*GROUP_W +: GROUP_W]),
                .hit   (w_g_hit[gi]),
                .idx   (w_g_idx[gi]),
                .multi (w_g_multi[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_g_hit    <= '0;
            r_g_idx    <= '0;
            r_g_multi  <= '0;
        end else if (w_s1_adv) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_g_hit   <= w_g_hit;
                r_g_idx   <= w_g_idx;
                r_g_multi <= w_g_multi;
            end
        end
    end

    // Same encoder, now choosing the lowest hitting group.
    prio16 u_sel (
        .vec   (r_g_hit),
        .hit   (w_sel_hit),
        .idx   (w_sel_grp),
        .multi (w_sel_multi)
    );

    assign w_addr  = w_sel_hit ? {w_sel_grp, r_g_idx[w_sel_grp]} : '0;
    assign w_multi = w_sel_hit && (w_sel_multi || r_g_multi[w_sel_grp]);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_hit   <= 1'b0;
            r_out_addr  <= '0;
            r_out_multi <= 1'b0;
        end else if (w_s2_adv) begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_out_hit   <= w_sel_hit;
                r_out_addr  <= w_addr;
                r_out_multi <= w_multi;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else if (w_out_hs) begin
            if (r_out_hit) begin
                if (r_hit_cnt != '1) r_hit_cnt <= r_hit_cnt + CNT_W'(1);
            end else begin
                if (r_miss_cnt != '1) r_miss_cnt <= r_miss_cnt + CNT_W'(1);
            end
        end
    end

    assign in_ready  = w_s1_adv;
    assign out_valid = r_out_valid;
    assign out_hit   = r_out_hit;
    assign out_addr  = r_out_addr;
    assign out_multi = r_out_multi;
    assign hit_cnt   = r_hit_cnt;
    assign miss_cnt  = r_miss_cnt;

endmodule
`default_nettype wire

// File: tb/tb_tcam_prio_enc.sv
`default_nettype none
// ============================================================================
// Module      : tb_tcam_prio_enc
// Description : Self-checking bench for tcam_prio_enc against a queue model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tcam_prio_enc;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [255:0] match;
    logic         out_valid;
    logic         out_ready;
    logic         out_hit;
    logic [7:0]   out_addr;
    logic         out_multi;
    logic         cnt_clr;
    logic [15:0]  hit_cnt;
    logic [15:0]  miss_cnt;

    tcam_prio_enc dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .match     (match),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_hit   (out_hit),
        .out_addr  (out_addr),
        .out_multi (out_multi),
        .cnt_clr   (cnt_clr),
        .hit_cnt   (hit_cnt),
        .miss_cnt  (miss_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       h;
        logic [7:0] a;
        logic       m;
        int         t;
    } res_t;

    res_t       q[$];
    logic [7:0] seen[$];
    int         n_chk  = 0;
    int         n_fail = 0;
    int         cyc    = 0;
    int         n_out_hs = 0;
    int         mh = 0;
    int         mm = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Lowest set index wins; multi means at least two set bits anywhere.
    function automatic res_t ref_enc(input logic [255:0] v, input int t);
        res_t r;
        int   n = 0;
        r.a = 8'd0;
        for (int i = 255; i >= 0; i--) begin
            if (v[i]) begin
                r.a = 8'(i);
                n++;
            end
        end
        r.h = (n > 0);
        r.m = (n > 1);
        r.t = t;
        return r;
    endfunction

    function automatic logic [255:0] onehot(input int i);
        logic [255:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    function automatic logic [255:0] rand_vec();
        logic [255:0] v;
        v = '0;
        case ($urandom % 4)
            0: v = '0;
            1: v[$urandom % 256] = 1'b1;
            2: begin v[$urandom % 256] = 1'b1; v[$urandom % 256] = 1'b1; end
            default: for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        endcase
        return v;
    endfunction

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            q.delete();
            mh = 0;
            mm = 0;
        end else begin
            chk("in_ready", {31'b0, in_ready},
                {31'b0, !(q.size() >= 2 && !out_ready)});
            chk("out_valid", {31'b0, out_valid},
                {31'b0, (q.size() > 0) && (cyc - q[0].t >= 2)});
            if (out_valid && q.size() > 0) begin
                chk("out_hit", {31'b0, out_hit}, {31'b0, q[0].h});
                chk("out_addr", {24'b0, out_addr}, {24'b0, q[0].a});
                chk("out_multi", {31'b0, out_multi}, {31'b0, q[0].m});
            end
            chk("hit_cnt", {16'b0, hit_cnt}, mh);
            chk("miss_cnt", {16'b0, miss_cnt}, mm);

            if (cnt_clr) begin
                mh = 0;
                mm = 0;
            end
            if (out_valid && out_ready) begin
                n_out_hs++;
                seen.push_back(out_addr);
                if (q.size() > 0) begin
                    if (!cnt_clr) begin
                        if (q[0].h) mh = (mh < 16'hFFFF) ? mh + 1 : mh;
                        else        mm = (mm < 16'hFFFF) ? mm + 1 : mm;
                    end
                    void'(q.pop_front());
                end
            end
            if (in_valid && in_ready) q.push_back(ref_enc(match, cyc));
        end
    end

    task automatic send(input logic [255:0] v);
        int k = 0;
        in_valid = 1'b1;
        match    = v;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            k++;
            if (k > 200) begin
                chk("send_timeout", 32'd1, 32'd0);
                break;
            end
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        match    = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic expect_out(input string nm, input logic h, input logic [7:0] a, input logic m);
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!out_valid && k < 50);
        if (!out_valid) begin
            chk({nm, "_timeout"}, 32'd1, 32'd0);
        end else begin
            chk({nm, "_hit"}, {31'b0, out_hit}, {31'b0, h});
            chk({nm, "_addr"}, {24'b0, out_addr}, {24'b0, a});
            chk({nm, "_multi"}, {31'b0, out_multi}, {31'b0, m});
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #950000;
        $display("FAIL watchdog: simulation did not finish, limit 950000 required");
        $fatal(1);
    end

    initial begin
        logic [255:0] v;
        int           m0;
        int           hs0;

        rst = 1'b1; in_valid = 1'b0; match = '0; out_ready = 1'b1; cnt_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_out_hit", {31'b0, out_hit}, 32'd0);
        chk("rst_out_addr", {24'b0, out_addr}, 32'd0);
        chk("rst_out_multi", {31'b0, out_multi}, 32'd0);
        chk("rst_hit_cnt", {16'b0, hit_cnt}, 32'd0);
        chk("rst_miss_cnt", {16'b0, miss_cnt}, 32'd0);
        @(posedge clk); #1;

        send(256'h1);
        expect_out("bit0", 1'b1, 8'd0, 1'b0);
        @(negedge clk);
        chk("bit0_hit_cnt", {16'b0, hit_cnt}, 32'd1);
        @(posedge clk); #1;

        v = '0; v[200] = 1'b1; v[37] = 1'b1;
        send(v);
        expect_out("b200_37", 1'b1, 8'h25, 1'b1);
        send(onehot(255));
        expect_out("b255", 1'b1, 8'd255, 1'b0);

        m0 = int'(miss_cnt);
        send('0);
        expect_out("zero", 1'b0, 8'd0, 1'b0);
        @(negedge clk);
        chk("zero_miss_cnt", {16'b0, miss_cnt}, m0 + 1);
        @(posedge clk); #1;

        seen.delete();
        out_ready = 1'b0;
        fork
            begin
                send(onehot(3)); send(onehot(17)); send(onehot(100)); send(onehot(254));
            end
            begin
                repeat (3) @(negedge clk);
                chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        repeat (8) @(posedge clk);
        #1;
        chk("bp_count", seen.size(), 32'd4);
        if (seen.size() == 4) begin
            chk("bp_ord0", {24'b0, seen[0]}, 32'd3);
            chk("bp_ord1", {24'b0, seen[1]}, 32'd17);
            chk("bp_ord2", {24'b0, seen[2]}, 32'd100);
            chk("bp_ord3", {24'b0, seen[3]}, 32'd254);
        end

        for (int i = 0; i < 2000; i++) begin
            in_valid  = ($urandom % 4) != 0;
            match     = rand_vec();
            out_ready = ($urandom % 3) != 0;
            cnt_clr   = ($urandom % 64) == 0;
            @(posedge clk); #1;
        end
        in_valid = 1'b0; cnt_clr = 1'b0; out_ready = 1'b1;
        repeat (6) @(posedge clk); #1;

        cnt_clr = 1'b1;
        @(posedge clk); #1;
        cnt_clr = 1'b0;
        for (int i = 0; i < 65537; i++) send(onehot($urandom % 256));
        repeat (4) @(posedge clk); #1;
        chk("sat_hit_cnt", {16'b0, hit_cnt}, 32'h0000FFFF);

        out_ready = 1'b0;
        send(onehot(9));
        repeat (3) @(posedge clk); #1;
        cnt_clr = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        cnt_clr = 1'b0;
        @(negedge clk);
        chk("clr_prio_hit_cnt", {16'b0, hit_cnt}, 32'd0);
        @(posedge clk); #1;

        out_ready = 1'b0;
        send(onehot(5));
        send(onehot(6));
        @(negedge clk); #1;
        hs0 = n_out_hs;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk); #1;
        chk("rst_mid_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_mid_hit_cnt", {16'b0, hit_cnt}, 32'd0);
        chk("rst_mid_miss_cnt", {16'b0, miss_cnt}, 32'd0);
        chk("rst_mid_out_addr", {24'b0, out_addr}, 32'd0);
        chk("rst_mid_in_ready", {31'b0, in_ready}, 32'd1);
        chk("rst_mid_no_hs", n_out_hs, hs0);
        out_ready = 1'b1;
        repeat (4) @(posedge clk); #1;
        chk("rst_mid_still_idle", {31'b0, out_valid}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
